// File: rtl/apb_cfg_seq_pkg.sv
// Shared types for the boot-table APB configuration sequencer.
package apb_cfg_seq_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_MAX_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR_SETUP,
    S_WR_ACCESS,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_SLVERR  = 2'b01,
    ERR_VERIFY  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     mask;
  } cfg_entry_t;

  function automatic logic verify_ok(input logic [DATA_W-1:0] rdata,
                                     input logic [DATA_W-1:0] data,
                                     input logic [DATA_W-1:0] mask);
    return ((rdata ^ data) & mask) == '0;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clearable saturating wait counter; expire flags the cycle whose stall reaches TIMEOUT_CYCLES.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && count != CNT_W'(TIMEOUT_CYCLES)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Look-ahead so the FSM leaves ACCESS on the edge that completes the last allowed stall cycle.
  assign expire = inc && (count >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_cfg_sequencer.sv
// APB master that applies a boot table of {addr, data, mask} writes with optional masked
// read-back verify, releasing the core via fetch_enable_o once the table is applied cleanly.
module apb_cfg_sequencer
  import apb_cfg_seq_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1,
  localparam int unsigned IDX_W         = $clog2(NUM_ENTRIES)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start_i,
  output logic [IDX_W-1:0]          tbl_idx_o,
  input  logic                      tbl_valid_i,
  input  logic [APB_ADDR_WIDTH-1:0] tbl_addr_i,
  input  logic [31:0]               tbl_data_i,
  input  logic [31:0]               tbl_mask_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [IDX_W-1:0]          err_idx_o,
  output logic [1:0]                err_code_o,
  output logic                      fetch_enable_o
);

  state_t     state;
  err_code_t  err_code;
  err_code_t  abort_code;
  cfg_entry_t cur;
  cfg_entry_t ent;
  logic [IDX_W-1:0] idx;
  logic auto_pend;
  logic abort;
  logic expire;
  logic in_setup;
  logic in_access;
  logic last;
  logic unused_ent;

  assign in_setup   = (state == S_WR_SETUP) || (state == S_RD_SETUP);
  assign in_access  = (state == S_WR_ACCESS) || (state == S_RD_ACCESS);
  assign last       = (idx == IDX_W'(NUM_ENTRIES - 1));
  assign tbl_idx_o  = idx;
  assign PADDR      = ent.addr[APB_ADDR_WIDTH-1:0];
  assign PWDATA     = ent.data;
  assign err_code_o = err_code;
  assign fetch_enable_o = done_o;
  assign unused_ent = ent.valid ^ (^ent.addr);

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (HCLK),
    .rst   (HRESET),
    .clr   (in_setup),
    .inc   (in_access && !PREADY),
    .expire(expire)
  );

  always_comb begin
    cur = '0;
    cur.valid = tbl_valid_i;
    cur.addr[APB_ADDR_WIDTH-1:0] = tbl_addr_i;
    cur.data = tbl_data_i;
    cur.mask = tbl_mask_i;
  end

  always_comb begin
    abort = 1'b0;
    abort_code = ERR_NONE;
    if (in_access) begin
      if (PREADY) begin
        if (PSLVERR) begin
          abort = 1'b1;
          abort_code = ERR_SLVERR;
        end else if (state == S_RD_ACCESS && !verify_ok(PRDATA, ent.data, ent.mask)) begin
          abort = 1'b1;
          abort_code = ERR_VERIFY;
        end
      end else if (expire) begin
        abort = 1'b1;
        abort_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      ent       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      err_idx_o <= '0;
      err_code  <= ERR_NONE;
      auto_pend <= AUTO_START;
    end else if (abort) begin
      state     <= S_ERROR;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      busy_o    <= 1'b0;
      error_o   <= 1'b1;
      err_idx_o <= idx;
      err_code  <= abort_code;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i || auto_pend) begin
            state     <= S_FETCH;
            idx       <= '0;
            busy_o    <= 1'b1;
            auto_pend <= 1'b0;
          end
        end
        S_FETCH: begin
          if (!tbl_valid_i) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            ent    <= cur;
            state  <= S_WR_SETUP;
            PSEL   <= 1'b1;
            PWRITE <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          state   <= S_WR_ACCESS;
          PENABLE <= 1'b1;
        end
        S_RD_SETUP: begin
          state   <= S_RD_ACCESS;
          PENABLE <= 1'b1;
        end
        S_WR_ACCESS, S_RD_ACCESS: begin
          if (PREADY) begin
            PENABLE <= 1'b0;
            // PSEL stays high into the read-back so the verify follows the write back-to-back.
            if (state == S_WR_ACCESS && ent.mask != '0) begin
              state  <= S_RD_SETUP;
              PWRITE <= 1'b0;
            end else begin
              PSEL <= 1'b0;
              if (last) begin
                state  <= S_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= S_FETCH;
              end
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (start_i) begin
            state    <= S_FETCH;
            idx      <= '0;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
